t_counter_mod: RTL and testbench



---
 rtl/t_counter_mod_if.sv | 13 +
 rtl/t_counter_mod.sv | 38 +++
 tb/tb_t_counter_mod.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/t_counter_mod_if.sv
// t_counter_mod_if: control/data bundle for the up/down modulo T-counter.
interface t_counter_mod_if #(parameter int WIDTH = 4);
  logic en;
  logic up_dn;
  logic load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] t_vec;
  logic tc;
  logic wrap;
  modport master(output en, up_dn, load, d, input Q, t_vec, tc, wrap);
  modport slave(input en, up_dn, load, d, output Q, t_vec, tc, wrap);
endinterface

// File: rtl/t_counter_mod.sv
// t_counter_mod: up/down modulo counter stored in toggle cells, clocked on the falling edge.
module t_counter_mod #(
  parameter int WIDTH = 4,
  parameter int MOD = 16
) (
  input logic clk,
  input logic rst,
  t_counter_mod_if.slave bus
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);
  logic [WIDTH-1:0] q_q, q_d, q_next, ld_val, step, t_vec;
  logic wrap_q, wrap_d, tc, at_top, at_zero;
  always_comb begin
    at_top = q_q == TOP;
    at_zero = q_q == '0;
    ld_val = ({1'b0, bus.d} < (WIDTH+1)'(MOD)) ? bus.d : TOP;
    step = bus.up_dn ? (at_top ? '0 : q_q + WIDTH'(1)) : (at_zero ? TOP : q_q - WIDTH'(1));
    q_next = rst ? '0 : bus.load ? ld_val : bus.en ? step : q_q;
    t_vec = q_next ^ q_q;
    tc = bus.en & ~bus.load & ~rst & (bus.up_dn ? at_top : at_zero);
    q_d = q_q ^ t_vec;
    wrap_d = tc;
  end
  // Each bit is a T cell: it only ever flips by its toggle input.
  always_ff @(negedge clk) begin
    if (rst) begin
      q_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q <= q_d;
      wrap_q <= wrap_d;
    end
  end
  assign bus.Q = q_q;
  assign bus.t_vec = t_vec;
  assign bus.tc = tc;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_t_counter_mod.sv
// tb_t_counter_mod: directed tests of the modulo T-counter in three configurations.
module tb_t_counter_mod;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  t_counter_mod_if #(.WIDTH(4)) ia();
  t_counter_mod_if #(.WIDTH(1)) ib();
  t_counter_mod_if #(.WIDTH(4)) ic();
  t_counter_mod #(.WIDTH(4), .MOD(10)) u_a (.clk(clk), .rst(rst), .bus(ia));
  t_counter_mod #(.WIDTH(1), .MOD(2)) u_b (.clk(clk), .rst(rst), .bus(ib));
  t_counter_mod #(.WIDTH(4), .MOD(16)) u_c (.clk(clk), .rst(rst), .bus(ic));

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    vectors++; if (ia.Q !== 4'd0) begin miscompares++; $display("FAIL reset_qa Q=%0d exp=0", ia.Q); end
    vectors++; if (ia.wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap wrap=%b exp=0", ia.wrap); end
    vectors++; if (ib.Q !== 1'b0) begin miscompares++; $display("FAIL reset_qb Q=%0d exp=0", ib.Q); end
    vectors++; if (ic.Q !== 4'd0) begin miscompares++; $display("FAIL reset_qc Q=%0d exp=0", ic.Q); end
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    int exp;
    ia.en = 1'b1; ia.up_dn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      vectors++; if (ia.tc !== (ia.Q == 4'd9)) begin miscompares++; $display("FAIL up_tc[%0d] tc=%b Q=%0d", i, ia.tc, ia.Q); end
      tick();
      exp = (i + 1) % 10;
      vectors++; if (ia.Q !== 4'(exp)) begin miscompares++; $display("FAIL up_q[%0d] Q=%0d exp=%0d", i, ia.Q, exp); end
      vectors++; if (ia.wrap !== (i == 9)) begin miscompares++; $display("FAIL up_wrap[%0d] wrap=%b exp=%b", i, ia.wrap, i == 9); end
    end
  endtask

  task automatic test_count_down();
    logic [3:0] exp_q [3] = '{4'd9, 4'd8, 4'd7};
    ia.load = 1'b1; ia.d = 4'd0;
    tick();
    ia.load = 1'b0; ia.en = 1'b1; ia.up_dn = 1'b0;
    #1;
    vectors++; if (ia.t_vec !== 4'b1001) begin miscompares++; $display("FAIL dn_tvec t_vec=%b exp=1001", ia.t_vec); end
    vectors++; if (ia.tc !== 1'b1) begin miscompares++; $display("FAIL dn_tc tc=%b exp=1", ia.tc); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (ia.Q !== exp_q[i]) begin miscompares++; $display("FAIL dn_q[%0d] Q=%0d exp=%0d", i, ia.Q, exp_q[i]); end
      vectors++; if (ia.wrap !== (i == 0)) begin miscompares++; $display("FAIL dn_wrap[%0d] wrap=%b exp=%b", i, ia.wrap, i == 0); end
    end
  endtask

  task automatic test_load();
    ia.load = 1'b1; ia.en = 1'b1; ia.up_dn = 1'b1; ia.d = 4'd7;
    tick();
    vectors++; if (ia.Q !== 4'd7) begin miscompares++; $display("FAIL load7 Q=%0d exp=7", ia.Q); end
    vectors++; if (ia.wrap !== 1'b0) begin miscompares++; $display("FAIL load7_wrap wrap=%b exp=0", ia.wrap); end
    ia.d = 4'd12;
    tick();
    vectors++; if (ia.Q !== 4'd9) begin miscompares++; $display("FAIL load12_sat Q=%0d exp=9", ia.Q); end
    ia.d = 4'd9;
    #1;
    vectors++; if (ia.tc !== 1'b0) begin miscompares++; $display("FAIL load_term_tc tc=%b exp=0", ia.tc); end
    tick();
    vectors++; if (ia.Q !== 4'd9) begin miscompares++; $display("FAIL load_term_q Q=%0d exp=9", ia.Q); end
    vectors++; if (ia.wrap !== 1'b0) begin miscompares++; $display("FAIL load_term_wrap wrap=%b exp=0", ia.wrap); end
    rst = 1'b1; ia.d = 4'd5;
    tick();
    rst = 1'b0;
    vectors++; if (ia.Q !== 4'd0) begin miscompares++; $display("FAIL load_rst Q=%0d exp=0", ia.Q); end
    ia.load = 1'b0;
  endtask

  task automatic test_hold_dir();
    logic [3:0] exp_q [4] = '{4'd6, 4'd5, 4'd6, 4'd5};
    ia.load = 1'b1; ia.d = 4'd5;
    tick();
    ia.load = 1'b0; ia.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (ia.t_vec !== 4'd0) begin miscompares++; $display("FAIL hold_tvec[%0d] t_vec=%b exp=0000", i, ia.t_vec); end
      tick();
      vectors++; if (ia.Q !== 4'd5) begin miscompares++; $display("FAIL hold_q[%0d] Q=%0d exp=5", i, ia.Q); end
    end
    ia.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ia.up_dn = (i % 2 == 0);
      tick();
      vectors++; if (ia.Q !== exp_q[i]) begin miscompares++; $display("FAIL dir_q[%0d] Q=%0d exp=%0d", i, ia.Q, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    ia.load = 1'b1; ia.d = 4'd9;
    tick();
    ia.load = 1'b0; ia.en = 1'b1; ia.up_dn = 1'b1;
    #1;
    vectors++; if (ia.tc !== 1'b1) begin miscompares++; $display("FAIL mid_tc tc=%b exp=1", ia.tc); end
    rst = 1'b1;
    #1;
    vectors++; if (ia.tc !== 1'b0) begin miscompares++; $display("FAIL mid_tc_rst tc=%b exp=0", ia.tc); end
    tick();
    rst = 1'b0;
    vectors++; if (ia.Q !== 4'd0) begin miscompares++; $display("FAIL mid_q Q=%0d exp=0", ia.Q); end
    vectors++; if (ia.wrap !== 1'b0) begin miscompares++; $display("FAIL mid_wrap wrap=%b exp=0", ia.wrap); end
    tick();
    vectors++; if (ia.Q !== 4'd1) begin miscompares++; $display("FAIL mid_resume Q=%0d exp=1", ia.Q); end
    ia.en = 1'b0;
  endtask

  task automatic test_degenerate_full();
    logic [3:0] exp_c [3] = '{4'd0, 4'd15, 4'd14};
    ib.en = 1'b1; ib.up_dn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (ib.Q !== 1'((i + 1) % 2)) begin miscompares++; $display("FAIL deg_q[%0d] Q=%0d exp=%0d", i, ib.Q, (i + 1) % 2); end
      vectors++; if (ib.wrap !== (i % 2 == 1)) begin miscompares++; $display("FAIL deg_wrap[%0d] wrap=%b exp=%b", i, ib.wrap, i % 2 == 1); end
    end
    ib.en = 1'b0;
    ic.load = 1'b1; ic.d = 4'd15;
    tick();
    vectors++; if (ic.Q !== 4'd15) begin miscompares++; $display("FAIL full_load Q=%0d exp=15", ic.Q); end
    ic.load = 1'b0; ic.en = 1'b1; ic.up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ic.up_dn = 1'b0;
      vectors++; if (ic.Q !== exp_c[i]) begin miscompares++; $display("FAIL full_q[%0d] Q=%0d exp=%0d", i, ic.Q, exp_c[i]); end
      vectors++; if (ic.wrap !== (i < 2)) begin miscompares++; $display("FAIL full_wrap[%0d] wrap=%b exp=%b", i, ic.wrap, i < 2); end
    end
    ic.en = 1'b0;
  endtask

  initial begin
    ia.en = 1'b0; ia.up_dn = 1'b1; ia.load = 1'b0; ia.d = '0;
    ib.en = 1'b0; ib.up_dn = 1'b1; ib.load = 1'b0; ib.d = '0;
    ic.en = 1'b0; ic.up_dn = 1'b1; ic.load = 1'b0; ic.d = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_hold_dir();
    test_reset_mid();
    test_degenerate_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
